uart_buffer_path: RTL and testbench

Byte-wide buffer datapath for the memory-mapped UART component. It routes host write data to one of four destinations through a 1:4 demultiplexer. A 2:1 multiplexer picks either the UART receiver byte or the host byte as the source for a 32-entry buffer RAM. The RAM has active-low write/read strobes and a registered read port. The UART controller FSM sits above it and drives every select, strobe and address.

---
 rtl/uart_buffer_path_if.sv | 34 +++
 rtl/uart_buffer_path.sv | 69 ++++++
 tb/tb_uart_buffer_path.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_buffer_path_if.sv
// Bus bundle for the UART buffer datapath: host/demux select and data,
// receiver byte, RAM address and strobes, and every datapath output.
interface uart_buffer_path_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 5
);
    logic [1:0]            demux_sel_i;
    logic [DATA_WIDTH-1:0] host_data_i;
    logic [DATA_WIDTH-1:0] demux0_o;
    logic [DATA_WIDTH-1:0] demux1_o;
    logic [DATA_WIDTH-1:0] demux2_o;
    logic [DATA_WIDTH-1:0] demux3_o;
    logic                  buff_sel_i;
    logic [DATA_WIDTH-1:0] rx_byte_i;
    logic [DATA_WIDTH-1:0] buff_in_o;
    logic [WORDS-1:0]      addr_i;
    logic                  wr_n_i;
    logic                  rd_n_i;
    logic [DATA_WIDTH-1:0] data_o;

    // Controller side: drives selects, data, address and strobes.
    modport master (
        output demux_sel_i, host_data_i, buff_sel_i, rx_byte_i,
               addr_i, wr_n_i, rd_n_i,
        input  demux0_o, demux1_o, demux2_o, demux3_o, buff_in_o, data_o
    );

    // Datapath side.
    modport slave (
        input  demux_sel_i, host_data_i, buff_sel_i, rx_byte_i,
               addr_i, wr_n_i, rd_n_i,
        output demux0_o, demux1_o, demux2_o, demux3_o, buff_in_o, data_o
    );
endinterface

// File: rtl/uart_buffer_path.sv
// UART buffer datapath: 1:4 host-data demux, rx/host source mux and a
// 2^WORDS x DATA_WIDTH buffer RAM with active-low strobes and a registered
// read port. All sequencing (selects, address, strobes) is owned by the
// controller above; this block only moves bytes.
module uart_buffer_path #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 5
) (
    input  logic                clock,
    input  logic                reset,
    uart_buffer_path_if.slave   bus
);
    localparam int DEPTH = 1 << WORDS;

    logic [DATA_WIDTH-1:0] demux_out [4];
    logic [DATA_WIDTH-1:0] buff_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q;

    // Demux: the selected lane carries host data, the other lanes are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_demux
            assign demux_out[gi] = (bus.demux_sel_i == 2'(gi)) ? bus.host_data_i : '0;
        end
    endgenerate

    assign bus.demux0_o = demux_out[0];
    assign bus.demux1_o = demux_out[1];
    assign bus.demux2_o = demux_out[2];
    assign bus.demux3_o = demux_out[3];

    // Source mux: host path goes through demux lane 3, so a host write with
    // any other demux select stores zero.
    assign buff_in      = bus.buff_sel_i ? demux_out[3] : bus.rx_byte_i;
    assign bus.buff_in_o = buff_in;

    // Strobe qualification: an edge with reset asserted (low) does nothing
    // to the array and performs no read.
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (reset) begin
            wr_en = ~bus.wr_n_i;
            rd_en = ~bus.rd_n_i;
        end
    end

    // Write port; contents survive reset (no clear sweep).
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[bus.addr_i] <= buff_in;
        end
    end

    // Registered read port; reading the old word on a same-edge write gives
    // read-before-write. Only the output register is cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem_q[bus.addr_i];
        end
    end

    assign bus.data_o = data_q;
endmodule

// File: tb/tb_uart_buffer_path.sv
// Testbench for uart_buffer_path: directed vectors with literal expectations,
// plus a behavioural model checked against the DUT every cycle.
module tb_uart_buffer_path;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    bit   run_checks;

    uart_buffer_path_if #(.DATA_WIDTH(DW), .WORDS(AW)) bus ();

    uart_buffer_path #(.DATA_WIDTH(DW), .WORDS(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] model_mem   [DEPTH];
    bit            model_known [DEPTH];
    logic [DW-1:0] exp_data;
    bit            exp_known;

    function automatic logic [DW-1:0] lane_value(input int lane, input logic [1:0] sel,
                                                 input logic [DW-1:0] host);
        return (int'(sel) == lane) ? host : 8'h00;
    endfunction

    function automatic logic [DW-1:0] ram_source(input logic bsel, input logic [1:0] sel,
                                                 input logic [DW-1:0] host, input logic [DW-1:0] rx);
        if (bsel) return (sel == 2'd3) ? host : 8'h00;
        return rx;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        exp_data  = '0;
        exp_known = 1'b0;
    end

    // Model update at each rising edge from the inputs held across that edge.
    always @(posedge clock) begin
        int a;
        logic [DW-1:0] old;
        a = int'(bus.addr_i);
        if (reset === 1'b0) begin
            exp_data  = '0;
            exp_known = 1'b1;
        end else begin
            old = model_mem[a];
            if (bus.rd_n_i === 1'b0) begin
                exp_data  = old;
                exp_known = model_known[a];
            end
            if (bus.wr_n_i === 1'b0) begin
                model_mem[a]   = ram_source(bus.buff_sel_i, bus.demux_sel_i,
                                            bus.host_data_i, bus.rx_byte_i);
                model_known[a] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clock) begin
        if (run_checks) begin
            checks++;
            if (bus.demux0_o !== lane_value(0, bus.demux_sel_i, bus.host_data_i) ||
                bus.demux1_o !== lane_value(1, bus.demux_sel_i, bus.host_data_i) ||
                bus.demux2_o !== lane_value(2, bus.demux_sel_i, bus.host_data_i) ||
                bus.demux3_o !== lane_value(3, bus.demux_sel_i, bus.host_data_i)) begin
                errors++;
                $display("FAIL cyc demux: got %h %h %h %h sel %0d host %h",
                         bus.demux0_o, bus.demux1_o, bus.demux2_o, bus.demux3_o,
                         bus.demux_sel_i, bus.host_data_i);
            end
            checks++;
            if (bus.buff_in_o !== ram_source(bus.buff_sel_i, bus.demux_sel_i,
                                             bus.host_data_i, bus.rx_byte_i)) begin
                errors++;
                $display("FAIL cyc buff_in_o: got %h expected %h", bus.buff_in_o,
                         ram_source(bus.buff_sel_i, bus.demux_sel_i, bus.host_data_i, bus.rx_byte_i));
            end
            if (exp_known) begin
                checks++;
                if (bus.data_o !== exp_data) begin
                    errors++;
                    $display("FAIL cyc data_o: got %h expected %h", bus.data_o, exp_data);
                end
            end
        end
    end

    // One clock edge; inputs change 2 time units after it.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_write(input logic [AW-1:0] a);
        bus.addr_i = a;
        bus.wr_n_i = 1'b0;
        tick();
        bus.wr_n_i = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bus.addr_i = a;
        bus.rd_n_i = 1'b0;
        tick();
        bus.rd_n_i = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        errors     = 0;
        checks     = 0;
        run_checks = 1'b0;
        reset           = 1'b0;
        bus.demux_sel_i = 2'd0;
        bus.host_data_i = 8'h00;
        bus.buff_sel_i  = 1'b0;
        bus.rx_byte_i   = 8'h00;
        bus.addr_i      = '0;
        bus.wr_n_i      = 1'b1;
        bus.rd_n_i      = 1'b1;

        tick();
        tick();
        run_checks = 1'b1;
        check("reset data_o", bus.data_o, 8'h00);
        reset = 1'b1;
        tick();

        // Demux sweep
        bus.host_data_i = 8'hA5;
        for (int s = 0; s < 4; s++) begin
            bus.demux_sel_i = 2'(s);
            #1;
            check($sformatf("sweep sel%0d demux0", s), bus.demux0_o, (s == 0) ? 8'hA5 : 8'h00);
            check($sformatf("sweep sel%0d demux1", s), bus.demux1_o, (s == 1) ? 8'hA5 : 8'h00);
            check($sformatf("sweep sel%0d demux2", s), bus.demux2_o, (s == 2) ? 8'hA5 : 8'h00);
            check($sformatf("sweep sel%0d demux3", s), bus.demux3_o, (s == 3) ? 8'hA5 : 8'h00);
            tick();
        end

        // Rx write path
        bus.buff_sel_i = 1'b0;
        bus.rx_byte_i  = 8'h3C;
        #1;
        check("rx buff_in_o", bus.buff_in_o, 8'h3C);
        do_write(5'd7);
        bus.rx_byte_i = 8'h00;
        do_read(5'd7);
        check("rx read addr7", bus.data_o, 8'h3C);

        // Hold with read strobe idle
        for (int k = 0; k < 5; k++) begin
            bus.addr_i = 5'(k);
            tick();
            check($sformatf("hold cycle %0d", k), bus.data_o, 8'h3C);
        end

        // Host write path through demux lane 3
        bus.buff_sel_i  = 1'b1;
        bus.demux_sel_i = 2'd3;
        bus.host_data_i = 8'h5A;
        #1;
        check("host buff_in_o sel3", bus.buff_in_o, 8'h5A);
        do_write(5'd31);
        do_read(5'd31);
        check("host read addr31", bus.data_o, 8'h5A);

        // Host write with demux steered elsewhere stores zero
        bus.demux_sel_i = 2'd1;
        #1;
        check("host buff_in_o sel1", bus.buff_in_o, 8'h00);
        do_write(5'd30);
        do_read(5'd30);
        check("host sel1 read addr30", bus.data_o, 8'h00);

        // Read-before-write at addr 4
        bus.buff_sel_i = 1'b0;
        bus.rx_byte_i  = 8'h11;
        do_write(5'd4);
        bus.rx_byte_i = 8'h22;
        bus.addr_i    = 5'd4;
        bus.wr_n_i    = 1'b0;
        bus.rd_n_i    = 1'b0;
        tick();
        bus.wr_n_i = 1'b1;
        bus.rd_n_i = 1'b1;
        check("rbw old value", bus.data_o, 8'h11);
        do_read(5'd4);
        check("rbw new value", bus.data_o, 8'h22);

        // Reset mid-operation with a write strobe pending
        do_read(5'd31);
        check("pre-reset data_o", bus.data_o, 8'h5A);
        bus.buff_sel_i  = 1'b1;
        bus.demux_sel_i = 2'd3;
        bus.host_data_i = 8'hFF;
        bus.addr_i      = 5'd31;
        bus.wr_n_i      = 1'b0;
        reset           = 1'b0;
        tick();
        check("reset clears data_o", bus.data_o, 8'h00);
        reset      = 1'b1;
        bus.wr_n_i = 1'b1;
        do_read(5'd31);
        check("addr31 survives reset", bus.data_o, 8'h5A);

        tick();
        run_checks = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
